zero_run_detector: RTL and testbench

//   Parametrised, registered successor to the 8-bit combinational zero detector.

---
 rtl/zero_run_detector_pkg.sv | 11 +
 rtl/zero_run_detector_zero_cmp.sv | 12 +
 rtl/zero_run_detector.sv | 125 ++++++++++++
 tb/tb_zero_run_detector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/zero_run_detector_pkg.sv
// Shared definitions for the zero run detector: FSM state encodings.
// 2'd3 is unused; the FSM recovers from it to S_IDLE on the next valid sample.
package zero_run_detector_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2
    } state_e;

endpackage

// File: rtl/zero_run_detector_zero_cmp.sv
// Combinational zero detector: parametrised reduction-NOR over the full word.
// Generalises the original 8-bit detector for reuse on any width.
module zero_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    output logic             is_zero
);

    assign is_zero = ~|din;

endmodule

// File: rtl/zero_run_detector.sv
// Registered zero-word detector with saturating consecutive-zero run counter.
// Optional sticky zero_seen flag when ZERO_STICKY_EN is defined.
module zero_run_detector
    import zero_run_detector_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic             zero_out,
`ifdef ZERO_STICKY_EN
    output logic             zero_seen,
`endif
    output logic [CNT_W-1:0] run_count,
    output logic             run_hit
);

    localparam logic [CNT_W-1:0] RUN_LEN_C = RUN_LEN[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             is_zero;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_out_q, zero_out_d;
    logic             run_hit_q, run_hit_d;
    state_e           st_eff;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] cnt_inc;

    zero_cmp #(.WIDTH(WIDTH)) u_cmp (
        .din     (din),
        .is_zero (is_zero)
    );

    // clr acts first, so a simultaneous sample starts a fresh run
    assign st_eff  = clr ? S_IDLE : state_q;
    assign cnt_eff = clr ? '0 : cnt_q;
    assign cnt_inc = cnt_eff + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        zero_out_d = zero_out_q;
        run_hit_d  = run_hit_q;
        if (clr) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            zero_out_d = 1'b0;
            run_hit_d  = 1'b0;
        end
        if (din_valid) begin
            zero_out_d = is_zero;
            if (!is_zero) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                case (st_eff)
                    S_IDLE: begin
                        cnt_d   = CNT_ONE;
                        state_d = (RUN_LEN == 1) ? S_HIT : S_RUN;
                    end
                    S_RUN: begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == RUN_LEN_C) ? S_HIT : S_RUN;
                    end
                    S_HIT: begin
                        cnt_d   = (cnt_eff == CNT_MAX) ? cnt_eff : cnt_inc;
                        state_d = S_HIT;
                    end
                    default: begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                endcase
            end
            run_hit_d = (state_d == S_HIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            zero_out_q <= 1'b0;
            run_hit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            zero_out_q <= zero_out_d;
            run_hit_q  <= run_hit_d;
        end
    end

    assign zero_out  = zero_out_q;
    assign run_count = cnt_q;
    assign run_hit   = run_hit_q;

`ifdef ZERO_STICKY_EN
    logic zero_seen_q, zero_seen_d;

    always_comb begin
        zero_seen_d = clr ? 1'b0 : zero_seen_q;
        if (din_valid && is_zero) begin
            zero_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_seen_q <= 1'b0;
        end else begin
            zero_seen_q <= zero_seen_d;
        end
    end

    assign zero_seen = zero_seen_q;
`endif

endmodule

// File: tb/tb_zero_run_detector.sv
// Scoreboard bench for zero_run_detector: default instance plus a CNT_W=3 instance.
// Define ZERO_STICKY_EN at compile time to also check zero_seen.
module tb_zero_run_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       clr = 1'b0;
    logic       chk = 1'b0;

    logic       z0, h0, z1, h1;
    logic [7:0] c0;
    logic [2:0] c1;
`ifdef ZERO_STICKY_EN
    logic       s0, s1;
`endif

    always #5 clk = ~clk;

    zero_run_detector #(.WIDTH(8), .RUN_LEN(4), .CNT_W(8)) u0 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clr       (clr),
        .zero_out  (z0),
`ifdef ZERO_STICKY_EN
        .zero_seen (s0),
`endif
        .run_count (c0),
        .run_hit   (h0)
    );

    zero_run_detector #(.WIDTH(8), .RUN_LEN(4), .CNT_W(3)) u1 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clr       (clr),
        .zero_out  (z1),
`ifdef ZERO_STICKY_EN
        .zero_seen (s1),
`endif
        .run_count (c1),
        .run_hit   (h1)
    );

    typedef struct {
        bit       which;
        bit       z;
        bit [7:0] cnt;
        bit       hit;
        bit       seen;
        string    name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic upd   = 1'b0;

    always @(posedge clk) upd <= rst | clr | din_valid | chk;

    // Monitor: one expected entry per cycle in which outputs may have changed
    always @(negedge clk) begin
        if (upd) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: output update with no expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (!e.which) begin
                    if (z0 !== e.z || c0 !== e.cnt || h0 !== e.hit) begin
                        bad++;
                        $display("FAIL %s: got z=%b cnt=%0d hit=%b want z=%b cnt=%0d hit=%b",
                                 e.name, z0, c0, h0, e.z, e.cnt, e.hit);
                    end
`ifdef ZERO_STICKY_EN
                    else if (s0 !== e.seen) begin
                        bad++;
                        $display("FAIL %s: got zero_seen=%b want %b", e.name, s0, e.seen);
                    end
`endif
                end else begin
                    if (z1 !== e.z || c1 !== e.cnt[2:0] || h1 !== e.hit) begin
                        bad++;
                        $display("FAIL %s: got z=%b cnt=%0d hit=%b want z=%b cnt=%0d hit=%b",
                                 e.name, z1, c1, h1, e.z, e.cnt, e.hit);
                    end
                end
            end
        end
    end

    task automatic step(input bit r, input bit c, input bit v, input bit [7:0] d,
                        input bit ck, input bit w, input bit ez, input bit [7:0] ec,
                        input bit eh, input bit es, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; clr = c; din_valid = v; din = d; chk = ck;
        e.which = w; e.z = ez; e.cnt = ec; e.hit = eh; e.seen = es; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        rst = 0; clr = 0; din_valid = 0; din = 8'hFF; chk = 0;
    endtask

    initial begin
        // 1: reset with valid zero present
        step(1,0,1,8'h00,0,0, 0,0,0,0, "rst_a");
        step(1,0,1,8'h00,0,0, 0,0,0,0, "rst_b");
        step(0,0,0,8'h00,1,0, 0,0,0,0, "rst_rel");
        // 2: four zeros reach RUN_LEN
        step(0,0,1,8'h00,0,0, 1,1,0,1, "run1");
        step(0,0,1,8'h00,0,0, 1,2,0,1, "run2");
        step(0,0,1,8'h00,0,0, 1,3,0,1, "run3");
        step(0,0,1,8'h00,0,0, 1,4,1,1, "run4_hit");
        step(0,0,0,8'h00,1,0, 1,4,1,1, "hold");
        step(0,0,1,8'h00,0,0, 1,5,1,1, "run5");
        step(0,0,1,8'h10,0,0, 0,0,0,1, "break_hit");
        // 3: run broken before RUN_LEN
        step(0,0,1,8'h00,0,0, 1,1,0,1, "b1");
        step(0,0,1,8'h00,0,0, 1,2,0,1, "b2");
        step(0,0,1,8'h05,0,0, 0,0,0,1, "b_nz");
        // 5: clr interactions
        step(0,0,1,8'h00,0,0, 1,1,0,1, "c1");
        step(0,0,1,8'h00,0,0, 1,2,0,1, "c2");
        step(0,0,1,8'h00,0,0, 1,3,0,1, "c3");
        step(0,1,1,8'h00,0,0, 1,1,0,1, "clr_zero");
        step(0,1,1,8'h80,0,0, 0,0,0,0, "clr_nz");
        step(0,0,1,8'h00,0,0, 1,1,0,1, "d1");
        step(0,0,1,8'h00,0,0, 1,2,0,1, "d2");
        step(0,0,1,8'h00,0,0, 1,3,0,1, "d3");
        step(0,0,1,8'h00,0,0, 1,4,1,1, "d4");
        step(0,1,1,8'h00,0,0, 1,1,0,1, "clr_hit_zero");
        step(0,1,0,8'h00,0,0, 0,0,0,0, "clr_only");
        // 4: CNT_W=3 saturation on u1
        step(0,0,1,8'h00,0,1, 1,1,0,0, "sat1");
        step(0,0,1,8'h00,0,1, 1,2,0,0, "sat2");
        step(0,0,1,8'h00,0,1, 1,3,0,0, "sat3");
        step(0,0,1,8'h00,0,1, 1,4,1,0, "sat4");
        step(0,0,1,8'h00,0,1, 1,5,1,0, "sat5");
        step(0,0,1,8'h00,0,1, 1,6,1,0, "sat6");
        step(0,0,1,8'h00,0,1, 1,7,1,0, "sat7");
        step(0,0,1,8'h00,0,1, 1,7,1,0, "sat8");
        step(0,0,1,8'h00,0,1, 1,7,1,0, "sat9");
        step(0,0,1,8'h00,0,1, 1,7,1,0, "sat10");
        step(0,0,1,8'h01,0,1, 0,0,0,0, "sat_break");
        // 6: sticky flag and reset mid-run
        step(1,0,0,8'h00,0,0, 0,0,0,0, "rst2");
        step(0,0,1,8'h00,0,0, 1,1,0,1, "s_zero");
        step(0,0,1,8'h01,0,0, 0,0,0,1, "s_nz1");
        step(0,0,1,8'h01,0,0, 0,0,0,1, "s_nz2");
        step(0,0,1,8'h01,0,0, 0,0,0,1, "s_nz3");
        step(0,1,0,8'h00,0,0, 0,0,0,0, "s_clr");
        step(0,0,1,8'h00,0,0, 1,1,0,1, "s_z1");
        step(0,0,1,8'h00,0,0, 1,2,0,1, "s_z2");
        step(1,0,1,8'h00,0,0, 0,0,0,0, "rst_mid");
        step(0,0,0,8'h00,1,0, 0,0,0,0, "post_rst");
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d leftover entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
